// File: rtl/writeback_stage_pkg.sv
// Shared types and widths for the writeback stage: source-select encoding,
// FSM states and the stage-register bundle.
package writeback_stage_pkg;

  localparam int VEC_W      = 128;
  localparam int REG_ADDR_W = 5;
  localparam int WB_DATA_W  = 16;

  typedef enum logic [1:0] {
    WB_SEL_MEM  = 2'b00,
    WB_SEL_ALU  = 2'b01,
    WB_SEL_ZERO = 2'b10,
    WB_SEL_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_VEC  = 1'b1
  } wb_state_e;

  // Selected values are latched, so later memory-stage changes cannot leak in
  typedef struct packed {
    logic                  wre;
    logic                  vwre;
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]  sdat;
    logic [VEC_W-1:0]      vdat;
  } wb_stage_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage bundle in, register-file write ports out, stall back to memory.
// slave = writeback stage view, master = memory stage / register file view.
interface writeback_stage_if #(
  parameter int LANE_W = 32
);
  import writeback_stage_pkg::*;

  localparam int NUM_LANES  = VEC_W / LANE_W;
  localparam int LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic                  wre_memory;
  logic                  vector_wre_memory;
  logic [1:0]            select_writeback_data_mux_memory;
  logic [1:0]            select_writeback_vector_data_mux_memory;
  logic [7:0]            data_from_memory;
  logic [7:0]            alu_result_memory;
  logic [VEC_W-1:0]      vector_data_from_memory;
  logic [VEC_W-1:0]      alu_vector_result_memory;
  logic [REG_ADDR_W-1:0] rd_memory;
  logic                  stall_memory;

  logic                  wre_writeback;
  logic [REG_ADDR_W-1:0] rd_writeback;
  logic [WB_DATA_W-1:0]  writeback_data;
  logic                  vector_wre_writeback;
  logic [REG_ADDR_W-1:0] vector_rd_writeback;
  logic [LANE_IDX_W-1:0] vector_lane_writeback;
  logic [LANE_W-1:0]     vector_lane_data_writeback;

  modport slave (
    input  wre_memory, vector_wre_memory,
    input  select_writeback_data_mux_memory, select_writeback_vector_data_mux_memory,
    input  data_from_memory, alu_result_memory,
    input  vector_data_from_memory, alu_vector_result_memory, rd_memory,
    output stall_memory,
    output wre_writeback, rd_writeback, writeback_data,
    output vector_wre_writeback, vector_rd_writeback,
    output vector_lane_writeback, vector_lane_data_writeback
  );

  modport master (
    output wre_memory, vector_wre_memory,
    output select_writeback_data_mux_memory, select_writeback_vector_data_mux_memory,
    output data_from_memory, alu_result_memory,
    output vector_data_from_memory, alu_vector_result_memory, rd_memory,
    input  stall_memory,
    input  wre_writeback, rd_writeback, writeback_data,
    input  vector_wre_writeback, vector_rd_writeback,
    input  vector_lane_writeback, vector_lane_data_writeback
  );

endinterface

// File: rtl/writeback_stage_lane_select.sv
// vector_lane_select: picks lane LANE_W-wide slice out of a 128-bit vector.
// Latency 0 (pure combinational); no backpressure.
// Lane 0 is the least significant slice.
module vector_lane_select
  import writeback_stage_pkg::*;
#(
  parameter int LANE_W = 32
) (
  input  logic [VEC_W-1:0]                          vec,
  input  logic [$clog2(VEC_W / LANE_W)-1:0]         lane,
  output logic [LANE_W-1:0]                         lane_dat
);

  assign lane_dat = vec[int'(lane) * LANE_W +: LANE_W];

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: muxes memory-stage results into scalar and lane-serialised vector RF writes.
// Latency 1 from capture to scalar write / vector beat 0; vector takes NUM_LANES beats.
// stall_memory holds the memory stage on all but the last beat. Option: WB_ZERO_REG_GUARD_EN.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int LANE_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  writeback_stage_if.slave  bus
);

  localparam int NUM_LANES  = VEC_W / LANE_W;
  localparam int LANE_IDX_W = $clog2(NUM_LANES);
  localparam logic [LANE_IDX_W-1:0] LAST_BEAT = LANE_IDX_W'(NUM_LANES - 1);

  wb_state_e             state;
  logic [LANE_IDX_W-1:0] beat;
  wb_stage_t             stage_q;
  wb_stage_t             stage_d;
  logic                  capture;
  logic                  last_beat;
  logic                  vec_active;
  logic                  scalar_en;
  logic                  reg_ok;
  logic [LANE_W-1:0]     lane_dat;

  assign vec_active = (state == WB_VEC);
  assign last_beat  = (beat == LAST_BEAT);
  assign bus.stall_memory = vec_active && !last_beat;
  assign capture    = !bus.stall_memory;

  always_comb begin
    stage_d      = '0;
    stage_d.wre  = bus.wre_memory;
    stage_d.vwre = bus.vector_wre_memory;
    stage_d.rd   = bus.rd_memory;
    case (wb_sel_e'(bus.select_writeback_data_mux_memory))
      WB_SEL_MEM: stage_d.sdat = {8'h00, bus.data_from_memory};
      WB_SEL_ALU: stage_d.sdat = {8'h00, bus.alu_result_memory};
      default:    stage_d.sdat = '0;
    endcase
    case (wb_sel_e'(bus.select_writeback_vector_data_mux_memory))
      WB_SEL_MEM: stage_d.vdat = bus.vector_data_from_memory;
      WB_SEL_ALU: stage_d.vdat = bus.alu_vector_result_memory;
      default:    stage_d.vdat = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= WB_IDLE;
      beat    <= '0;
      stage_q <= '0;
    end else begin
      if (capture) begin
        stage_q <= stage_d;
      end
      case (state)
        WB_IDLE: begin
          beat <= '0;
          if (capture && bus.vector_wre_memory) begin
            state <= WB_VEC;
          end
        end
        WB_VEC: begin
          if (last_beat) begin
            // A vector bundle captured on the final beat restarts without a gap
            beat  <= '0;
            state <= (capture && bus.vector_wre_memory) ? WB_VEC : WB_IDLE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: begin
          state <= WB_IDLE;
          beat  <= '0;
        end
      endcase
    end
  end

  vector_lane_select #(
    .LANE_W (LANE_W)
  ) u_lane_select (
    .vec      (stage_q.vdat),
    .lane     (beat),
    .lane_dat (lane_dat)
  );

`ifdef WB_ZERO_REG_GUARD_EN
  assign reg_ok = (stage_q.rd != '0);
`else
  assign reg_ok = 1'b1;
`endif

  // The stage register holds through a vector burst, so the scalar write is pinned to beat 0
  assign scalar_en = stage_q.wre && (!vec_active || (beat == '0));

  assign bus.wre_writeback              = scalar_en && reg_ok;
  assign bus.rd_writeback               = stage_q.rd;
  assign bus.writeback_data             = stage_q.sdat;
  assign bus.vector_wre_writeback       = vec_active && stage_q.vwre && reg_ok;
  assign bus.vector_rd_writeback        = stage_q.rd;
  assign bus.vector_lane_writeback      = vec_active ? beat : '0;
  assign bus.vector_lane_data_writeback = vec_active ? lane_dat : '0;

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter LANE_W, 32, vector register-file write-port width in bits; legal values 32 or 64; NUM_LANES = 128/LANE_W.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 wre_memory, vector_wre_memory  in  1 each  scalar/vector write enables from memory stage.
REQ-005 select_writeback_data_mux_memory, select_writeback_vector_data_mux_memory  in  2 each  source selects.
REQ-006 data_from_memory  in  8; alu_result_memory  in  8  scalar candidates.
REQ-007 vector_data_from_memory, alu_vector_result_memory  in  128 each  vector candidates.
REQ-008 rd_memory  in  5  destination register.
REQ-009 stall_memory  out  1  high = memory stage must hold its outputs this cycle.
REQ-010 wre_writeback  out  1; rd_writeback  out  5; writeback_data  out  16  scalar register-file write port.
REQ-011 vector_wre_writeback  out  1; vector_rd_writeback  out  5; vector_lane_writeback  out  log2(NUM_LANES); vector_lane_data_writeback  out  LANE_W  vector write port.

Function
REQ-012 Input bundle SHALL be captured into a stage register on each rising edge where stall_memory is low.
REQ-013 Scalar select: 2'b00 data_from_memory, 2'b01 alu_result_memory, 2'b10/2'b11 zero; SHALL zero-extend to 16 bits.
REQ-014 Vector select: same encoding over the 128-bit candidates.
REQ-015 Scalar write SHALL appear one cycle after capture (latency 1), from registered values only.
REQ-016 FSM states IDLE, VEC; IDLE->VEC on capture with vector_wre_memory=1; VEC->IDLE after beat NUM_LANES-1 unless a new vector bundle is captured on that same edge, then VEC restarts at beat 0.
REQ-017 In VEC, beat b SHALL drive vector_wre_writeback=1, vector_lane_writeback=b, vector_lane_data_writeback=selected vector [LANE_W*b +: LANE_W], lane 0 first.
REQ-018 stall_memory SHALL be high exactly when state is VEC and beat < NUM_LANES-1 (combinational from state).
REQ-019 Bundle with both wre and vector_wre: scalar write issued on beat 0 only.
REQ-020 Bundle with neither enable: no writes, no stall, stage register still updates.
REQ-021 Selected vector value SHALL be latched at capture; memory-stage changes during beats SHALL not affect lane data.
REQ-022 Beat counter SHALL wrap to 0 on leaving or restarting VEC; never exceeds NUM_LANES-1.

Reset
REQ-023 Asserting reset at any time, including mid-VEC, SHALL immediately force state IDLE, beat 0, all outputs 0, stage register 0.
REQ-024 After release, first capture occurs on first rising edge with reset high.

Configuration
REQ-025 Macro WB_ZERO_REG_GUARD_EN: when defined, wre_writeback and vector_wre_writeback SHALL be forced 0 whenever the target register is 0 (stall/beat sequencing unchanged); when undefined, writes to register 0 pass through.

Structure
REQ-026 Shared package SHALL hold wb_sel_e select encoding, wb_state_e FSM encoding, VEC_W=128 and REG_ADDR_W=5.
REQ-027 Lane slicing SHALL be one sub-module, vector_lane_select (128-bit in, lane index, LANE_W out); source muxing stays inline.

Verification
REQ-028 Reset low 2 cycles, release; scalar bundle wre=1, sel=01, alu=8'h01, rd=3 -> next cycle wre_writeback=1, rd_writeback=3, writeback_data=16'h0001, stall_memory=0.
REQ-029 Vector bundle sel=00, vector_data_from_memory=128'h00000004_00000003_00000002_00000001, rd=5, LANE_W=32 -> four cycles lanes 0..3 data 1,2,3,4; stall_memory high for first three, low on fourth.
REQ-030 Back-to-back vector bundles rd=5 then rd=6 -> eight consecutive write cycles, no idle gap, second bundle captured on lane-3 edge.
REQ-031 Combined bundle wre=1, vector_wre=1, rd=7 -> wre_writeback high on beat 0 only; vector beats 0..3 complete.
REQ-032 Reset asserted during beat 1 -> same instant all outputs 0, stall_memory 0; after release IDLE, no residual beats.
REQ-033 With WB_ZERO_REG_GUARD_EN, scalar and vector bundles rd=0 -> no write enables, vector still takes four cycles with stall pattern of REQ-029.
